// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM receiver; hunts for sync, collects slots 0..3 in shadow registers
// and publishes each complete frame atomically with a one-cycle valid pulse.
module tdm_demux4 #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [W-1:0]  id,
  input  logic          ivalid,
  input  logic          isync,
  output logic [W-1:0]  oz0,
  output logic [W-1:0]  oz1,
  output logic [W-1:0]  oz2,
  output logic [W-1:0]  oz3,
  output logic          ovalid,
  output logic [1:0]    oslot,
  output logic          olock,
  output logic          oerr,
  output logic [CW-1:0] oframes
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [W-1:0] sh0, sh1, sh2;
  logic start, mid, miss, early, done, err;
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= HUNT;
      ptr   <= 2'd0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end
  // Any sync beat starts a frame, whatever state we are in.
  always_comb begin
    state_n = start ? LOCKED : miss ? HUNT : state;
    ptr_n   = start ? 2'd1 : mid ? ptr + 2'd1 : miss ? 2'd0 : ptr;
  end
  always_comb begin
    start = ivalid & isync;
    mid   = ivalid & (state == LOCKED) & ~isync & (ptr != 2'd0);
    miss  = ivalid & (state == LOCKED) & ~isync & (ptr == 2'd0);
    early = ivalid & (state == LOCKED) & isync & (ptr != 2'd0);
    done  = mid & (ptr == 2'd3);
    err   = miss | early;
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      sh0     <= '0;
      sh1     <= '0;
      sh2     <= '0;
      oz0     <= '0;
      oz1     <= '0;
      oz2     <= '0;
      oz3     <= '0;
      ovalid  <= 1'b0;
      oerr    <= 1'b0;
      oframes <= '0;
    end else begin
      ovalid <= done;
      oerr   <= err;
      if (start) sh0 <= id;
      if (mid && ptr == 2'd1) sh1 <= id;
      if (mid && ptr == 2'd2) sh2 <= id;
      if (done) begin
        oz0     <= sh0;
        oz1     <= sh1;
        oz2     <= sh2;
        oz3     <= id;
        oframes <= oframes + CW'(1);
      end
    end
  end
  assign oslot = ptr;
  assign olock = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed vector table plus a hand-written hold sequence for tdm_demux4 (CW=2 to exercise wrap).
module tb_tdm_demux4;
  typedef struct packed {
    logic       rst;
    logic       v;
    logic       s;
    logic [3:0] d;
    logic [22:0] exp;
  } vec_t;
  logic clk = 0;
  logic irst = 1, ivalid = 0, isync = 0;
  logic [3:0] id = 0;
  logic [3:0] oz0, oz1, oz2, oz3;
  logic ovalid, olock, oerr;
  logic [1:0] oslot, oframes;
  int errors = 0, checks = 0;
  vec_t tbl[41];
  always #5 clk = ~clk;
  tdm_demux4 #(.W(4), .CW(2)) dut (
    .iclk(clk), .irst(irst), .id(id), .ivalid(ivalid), .isync(isync),
    .oz0(oz0), .oz1(oz1), .oz2(oz2), .oz3(oz3), .ovalid(ovalid),
    .oslot(oslot), .olock(olock), .oerr(oerr), .oframes(oframes)
  );
  function automatic vec_t mk(input logic r, v, s, input logic [3:0] d,
                              input logic [15:0] z, input logic ov, input logic [1:0] sl,
                              input logic lk, er, input logic [1:0] fr);
    return '{rst: r, v: v, s: s, d: d, exp: {z, ov, sl, lk, er, fr}};
  endfunction
  function automatic logic [22:0] got();
    return {oz0, oz1, oz2, oz3, ovalid, oslot, olock, oerr, oframes};
  endfunction
  task automatic step(input logic r, v, s, input logic [3:0] d);
    @(negedge clk);
    irst = r; ivalid = v; isync = s; id = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [22:0] exp);
    checks++;
    if (got() !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got(), exp);
    end
  endtask
  initial begin
    tbl[0]  = mk(1,1,1,4'h5, 16'h0000,0,0,0,0,0);
    tbl[1]  = mk(1,1,1,4'h5, 16'h0000,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,4'h0, 16'h0000,0,0,0,0,0);
    tbl[3]  = mk(0,1,1,4'h1, 16'h0000,0,1,1,0,0);
    tbl[4]  = mk(0,1,0,4'h2, 16'h0000,0,2,1,0,0);
    tbl[5]  = mk(0,1,0,4'h3, 16'h0000,0,3,1,0,0);
    tbl[6]  = mk(0,1,0,4'h4, 16'h1234,1,0,1,0,1);
    tbl[7]  = mk(0,0,0,4'h0, 16'h1234,0,0,1,0,1);
    tbl[8]  = mk(0,1,1,4'hA, 16'h1234,0,1,1,0,1);
    tbl[9]  = mk(0,0,0,4'h0, 16'h1234,0,1,1,0,1);
    tbl[10] = mk(0,1,0,4'hB, 16'h1234,0,2,1,0,1);
    tbl[11] = mk(0,0,0,4'h0, 16'h1234,0,2,1,0,1);
    tbl[12] = mk(0,1,0,4'hC, 16'h1234,0,3,1,0,1);
    tbl[13] = mk(0,0,1,4'hF, 16'h1234,0,3,1,0,1);
    tbl[14] = mk(0,1,0,4'hD, 16'hABCD,1,0,1,0,2);
    tbl[15] = mk(0,1,1,4'h5, 16'hABCD,0,1,1,0,2);
    tbl[16] = mk(0,1,0,4'h6, 16'hABCD,0,2,1,0,2);
    tbl[17] = mk(0,1,0,4'h7, 16'hABCD,0,3,1,0,2);
    tbl[18] = mk(0,1,0,4'h8, 16'h5678,1,0,1,0,3);
    tbl[19] = mk(0,1,1,4'h1, 16'h5678,0,1,1,0,3);
    tbl[20] = mk(0,1,0,4'h2, 16'h5678,0,2,1,0,3);
    tbl[21] = mk(0,1,1,4'h9, 16'h5678,0,1,1,1,3);
    tbl[22] = mk(0,1,0,4'hA, 16'h5678,0,2,1,0,3);
    tbl[23] = mk(0,1,0,4'hB, 16'h5678,0,3,1,0,3);
    tbl[24] = mk(0,1,0,4'hC, 16'h9ABC,1,0,1,0,0);
    tbl[25] = mk(0,1,0,4'h7, 16'h9ABC,0,0,0,1,0);
    tbl[26] = mk(0,1,0,4'h3, 16'h9ABC,0,0,0,0,0);
    tbl[27] = mk(0,1,0,4'h3, 16'h9ABC,0,0,0,0,0);
    tbl[28] = mk(0,1,1,4'h1, 16'h9ABC,0,1,1,0,0);
    tbl[29] = mk(0,1,0,4'h2, 16'h9ABC,0,2,1,0,0);
    tbl[30] = mk(0,1,0,4'h3, 16'h9ABC,0,3,1,0,0);
    tbl[31] = mk(0,1,0,4'h4, 16'h1234,1,0,1,0,1);
    tbl[32] = mk(0,0,1,4'hF, 16'h1234,0,0,1,0,1);
    tbl[33] = mk(0,1,1,4'h6, 16'h1234,0,1,1,0,1);
    tbl[34] = mk(0,1,0,4'h7, 16'h1234,0,2,1,0,1);
    tbl[35] = mk(1,1,0,4'h8, 16'h0000,0,0,0,0,0);
    tbl[36] = mk(0,1,0,4'h9, 16'h0000,0,0,0,0,0);
    tbl[37] = mk(0,1,1,4'h1, 16'h0000,0,1,1,0,0);
    tbl[38] = mk(0,1,0,4'h2, 16'h0000,0,2,1,0,0);
    tbl[39] = mk(0,1,0,4'h3, 16'h0000,0,3,1,0,0);
    tbl[40] = mk(0,1,0,4'h4, 16'h1234,1,0,1,0,1);
    for (int i = 0; i < 41; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    step(0,1,1,4'h3);
    step(0,1,0,4'h5);
    step(0,0,0,4'h0);
    step(0,1,0,4'h7);
    check("hold_pre", {16'h1234,1'b0,2'd3,1'b1,1'b0,2'd1});
    step(0,1,0,4'h9);
    check("hold_frame", {16'h3579,1'b1,2'd0,1'b1,1'b0,2'd2});
    for (int i = 0; i < 5; i++) begin
      step(0,0,i[0],4'hE);
      check($sformatf("hold%0d", i), {16'h3579,1'b0,2'd0,1'b1,1'b0,2'd2});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
